// File: rtl/btn_input_ctrl.sv
// Debounced multi-channel button front end with press/release edges
// and per-channel auto-repeat.
//
// Ports:
//   Clk      - rising-edge clock
//   Rst      - synchronous active-high reset
//   Btn      - raw asynchronous button pins (polarity per ACTIVE_LOW)
//   RepeatEn - per-channel auto-repeat enable
//   Level    - debounced pressed state, 1 = pressed
//   Press    - one-cycle pulse on the first pressed cycle
//   Release  - one-cycle pulse on the first released cycle
//   Fire     - Press OR auto-repeat pulse
module btn_input_ctrl #(
  parameter int N_BTN        = 4,
  parameter int DEB_CYCLES   = 4,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 8,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [N_BTN-1:0] Btn,
  input  logic [N_BTN-1:0] RepeatEn,
  output logic [N_BTN-1:0] Level,
  output logic [N_BTN-1:0] Press,
  output logic [N_BTN-1:0] Release,
  output logic [N_BTN-1:0] Fire
);

  localparam int DW   = $clog2(DEB_CYCLES + 1);
  localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] RD_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] RR_LAST  = HW'(REPEAT_RATE - 1);

  // Pin value of a released button.
  localparam logic [N_BTN-1:0] REL_V = {N_BTN{ACTIVE_LOW != 0}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_WAIT = 2'd1,
    REPEATING = 2'd2
  } state_t;

  logic [N_BTN-1:0] r_s1;
  logic [N_BTN-1:0] r_s2;
  logic [N_BTN-1:0] r_level;
  logic [N_BTN-1:0] r_press;
  logic [N_BTN-1:0] r_rel;
  logic [N_BTN-1:0] r_fire;
  logic [DW-1:0]    r_deb  [N_BTN];
  logic [HW-1:0]    r_hold [N_BTN];
  state_t           r_st   [N_BTN];

  logic [N_BTN-1:0] w_pressed;
  logic [N_BTN-1:0] w_diff;
  logic [N_BTN-1:0] w_tgl;
  logic [N_BTN-1:0] w_press_ev;
  logic [N_BTN-1:0] w_rel_ev;
  logic [N_BTN-1:0] w_rep;
  logic [HW-1:0]    w_hold_nxt [N_BTN];
  state_t           w_st_nxt   [N_BTN];

  assign w_pressed = r_s2 ^ REL_V;

  always_comb begin
    w_diff     = '0;
    w_tgl      = '0;
    w_press_ev = '0;
    w_rel_ev   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_diff[i]     = w_pressed[i] != r_level[i];
      // The last differing sample flips Level on this edge.
      w_tgl[i]      = w_diff[i] && (r_deb[i] == DEB_LAST);
      w_press_ev[i] = w_tgl[i] && !r_level[i];
      w_rel_ev[i]   = w_tgl[i] && r_level[i];
    end
  end

  always_comb begin
    w_rep = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_st_nxt[i]   = r_st[i];
      w_hold_nxt[i] = r_hold[i];
      // Release wins over everything, so a repeat due now is dropped.
      if (w_rel_ev[i]) begin
        w_st_nxt[i]   = IDLE;
        w_hold_nxt[i] = '0;
      end else begin
        unique case (r_st[i])
          IDLE: begin
            if (w_press_ev[i]) begin
              w_st_nxt[i]   = HOLD_WAIT;
              w_hold_nxt[i] = '0;
            end
          end
          HOLD_WAIT: begin
            if (!RepeatEn[i]) begin
              w_hold_nxt[i] = '0;
            end else if (r_hold[i] == RD_LAST) begin
              w_rep[i]      = 1'b1;
              w_st_nxt[i]   = REPEATING;
              w_hold_nxt[i] = '0;
            end else begin
              w_hold_nxt[i] = r_hold[i] + 1'b1;
            end
          end
          REPEATING: begin
            if (!RepeatEn[i]) begin
              w_st_nxt[i]   = HOLD_WAIT;
              w_hold_nxt[i] = '0;
            end else if (r_hold[i] == RR_LAST) begin
              w_rep[i]      = 1'b1;
              w_hold_nxt[i] = '0;
            end else begin
              w_hold_nxt[i] = r_hold[i] + 1'b1;
            end
          end
          default: begin
            w_st_nxt[i]   = IDLE;
            w_hold_nxt[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_s1    <= REL_V;
      r_s2    <= REL_V;
      r_level <= '0;
      r_press <= '0;
      r_rel   <= '0;
      r_fire  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_deb[i]  <= '0;
        r_hold[i] <= '0;
        r_st[i]   <= IDLE;
      end
    end else begin
      r_s1    <= Btn;
      r_s2    <= r_s1;
      r_level <= r_level ^ w_tgl;
      r_press <= w_press_ev;
      r_rel   <= w_rel_ev;
      r_fire  <= w_press_ev | w_rep;
      for (int i = 0; i < N_BTN; i++) begin
        if (!w_diff[i] || w_tgl[i])
          r_deb[i] <= '0;
        else
          r_deb[i] <= r_deb[i] + 1'b1;
        r_hold[i] <= w_hold_nxt[i];
        r_st[i]   <= w_st_nxt[i];
      end
    end
  end

  assign Level   = r_level;
  assign Press   = r_press;
  assign Release = r_rel;
  assign Fire    = r_fire;

endmodule

// File: doc/btn_input_ctrl.md
BTN_INPUT_CTRL -- requirements
Module: btn_input_ctrl

Interface
REQ-001 The block SHALL have parameter N_BTN, default 4, number of button channels.
REQ-002 The block SHALL have parameter DEB_CYCLES, default 4, consecutive stable samples needed to accept a level change (>=1).
REQ-003 The block SHALL have parameter REPEAT_DELAY, default 16, cycles from Press to first auto-repeat (>=2).
REQ-004 The block SHALL have parameter REPEAT_RATE, default 8, cycles between later auto-repeats (>=1).
REQ-005 The block SHALL have parameter ACTIVE_LOW, default 1; 1 means Btn=0 is pressed.
REQ-006 The block SHALL have port Clk  input  1  the only clock, rising-edge.
REQ-007 The block SHALL have port Rst  input  1  synchronous, active-high reset.
REQ-008 The block SHALL have port Btn  input  N_BTN  raw asynchronous button pins.
REQ-009 The block SHALL have port RepeatEn  input  N_BTN  per-channel auto-repeat enable.
REQ-010 The block SHALL have port Level  output  N_BTN  debounced pressed state, 1 = pressed.
REQ-011 The block SHALL have port Press  output  N_BTN  one-cycle pulse on debounced press.
REQ-012 The block SHALL have port Release  output  N_BTN  one-cycle pulse on debounced release.
REQ-013 The block SHALL have port Fire  output  N_BTN  Press OR auto-repeat pulse.

Function
REQ-014 Each channel SHALL pass Btn through a 2-flop synchronizer and then normalise it to pressed=1 per ACTIVE_LOW.
REQ-015 Channels SHALL be fully independent, with no shared counters or arbitration.
REQ-016 Debounce: while the synchronised value differs from Level, a per-channel counter SHALL increment each cycle, and it SHALL clear whenever they match.
REQ-017 Level SHALL toggle once DEB_CYCLES consecutive differing samples are counted, and the counter SHALL clear on that same edge.
REQ-018 Latency: with Btn held stable, Level SHALL change on rising edge DEB_CYCLES+2 after the Btn change (edge 6 at defaults).
REQ-019 Any input pulse shorter than DEB_CYCLES synchronised samples SHALL produce no Level, Press, Release or Fire activity.
REQ-020 Press SHALL be high for exactly the first cycle in which Level is 1; Release SHALL be high for exactly the first cycle in which Level is 0 after being 1.
REQ-021 Per-channel FSM states SHALL be IDLE, HOLD_WAIT and REPEATING.
REQ-022 IDLE SHALL go to HOLD_WAIT on Press, clearing the hold counter.
REQ-023 In HOLD_WAIT with RepeatEn=1, the hold counter SHALL increment each cycle, and at count REPEAT_DELAY the FSM SHALL emit one repeat pulse, go to REPEATING and clear the counter.
REQ-024 In REPEATING, the FSM SHALL emit one repeat pulse every REPEAT_RATE cycles.
REQ-025 Debounced release SHALL return the FSM from any state to IDLE, clear the hold counter, and emit no further repeat pulses; a repeat due on the release cycle SHALL be suppressed.
REQ-026 While RepeatEn=0, the FSM SHALL hold the counter at 0 and return to HOLD_WAIT from REPEATING; re-enable SHALL restart the REPEAT_DELAY timing.
REQ-027 Fire SHALL equal Press OR the repeat pulse, registered and aligned with Press; Press and a repeat SHALL never coincide.
REQ-028 Counter widths SHALL be $clog2(max+1) of their limits, with no wrap-around before the compare point.
REQ-029 All outputs SHALL be registered, with no combinational path from Btn to any output.

Reset
REQ-030 While Rst=1, the synchronizers SHALL load the released value, and Level, Press, Release, Fire, all counters and the FSM (IDLE) SHALL be 0 on the next edge.
REQ-031 Reset SHALL override any debounce or repeat activity in progress, and no Release pulse SHALL be generated by reset.
REQ-032 A button held through reset SHALL be treated as a new press, with Press on edge DEB_CYCLES+2 after Rst falls, counting from the synchronizer refill.

Verification
REQ-033 Rst=1 for 3 cycles with Btn=4'b1111 -> Level=Press=Release=Fire=4'b0000 throughout and after release.
REQ-034 Btn=4'b1110 held 20 cycles, RepeatEn=0 -> Level[0] rises on edge 6; Press[0] and Fire[0] pulse once on edge 6; no other Fire; Btn back to 1111 -> Release[0] 6 edges later.
REQ-035 Btn[1]=0 for 3 cycles, then 1 -> no activity on any output.
REQ-036 Btn=4'b1011 held 40 cycles, RepeatEn=4'b0100 -> Fire[2] on edges 6, 22, 30, 38; Press[2] only on edge 6.
REQ-037 Btn=4'b0000 for 10 cycles, then 4'b1111 -> Press=4'b1111 together on edge 6; Release=4'b1111 together on edge 6 after the return.
REQ-038 Rst pulsed 1 cycle during REPEATING with button still held -> outputs 0 the next cycle; Press reissued 6 edges after Rst falls; first repeat 16 cycles after that.
